// File: rtl/mgmt_rr_arbiter.sv
// mgmt_rr_arbiter
// Merges two AXI4-Stream inputs onto one output stream. The grant changes only
// at packet boundaries. Weighted round robin: the pointer port keeps priority
// for "credit" packets, then the pointer moves to the other port and the credit
// is reloaded from that port's weight (a weight of 0 counts as 1).
// The data path is a zero-latency multiplexer selected by the FSM state.
module mgmt_rr_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                              s_axis_tvalid_0,
    input  logic                              s_axis_tlast_0,
    output logic                              s_axis_tready_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                              s_axis_tvalid_1,
    input  logic                              s_axis_tlast_1,
    output logic                              s_axis_tready_1,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_cnt_0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_cnt_1,
    output logic [1:0]                        grant_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEND0 = 2'b01,
        SEND1 = 2'b10
    } state_t;

    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ZERO = {C_S_AXI_DATA_WIDTH{1'b0}};
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE  = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

    // A programmed weight of zero still grants one packet per turn.
    function automatic logic [7:0] eff_weight(input logic [7:0] weight);
        logic [7:0] result;
        if (weight == 8'd0) begin
            result = 8'd1;
        end else begin
            result = weight;
        end
        return result;
    endfunction

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic                            ptr_r;
    logic                            ptr_nxt_s;
    logic [7:0]                      credit_r;
    logic [7:0]                      credit_nxt_s;
    logic [7:0]                      credit_dec_s;
    logic [7:0]                      other_weight_s;
    logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_cnt_0_r;
    logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_cnt_1_r;
    logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_cnt_0_nxt_s;
    logic [C_S_AXI_DATA_WIDTH-1:0]   pkt_cnt_1_nxt_s;
    logic                            elig0_s;
    logic                            elig1_s;
    logic                            ptr_elig_s;
    logic                            other_elig_s;
    logic                            last0_s;
    logic                            last1_s;
    logic                            pkt_done_s;
    logic                            inc0_s;
    logic                            inc1_s;
    logic                            cnt_clr_s;
    logic                            unused_ctrl_s;

    assign elig0_s        = ctrl_reg[0] & s_axis_tvalid_0;
    assign elig1_s        = ctrl_reg[1] & s_axis_tvalid_1;
    assign ptr_elig_s     = ptr_r ? elig1_s : elig0_s;
    assign other_elig_s   = ptr_r ? elig0_s : elig1_s;
    assign other_weight_s = ptr_r ? eff_weight(ctrl_reg[15:8]) : eff_weight(ctrl_reg[23:16]);
    assign credit_dec_s   = credit_r - 8'd1;
    assign cnt_clr_s      = ctrl_reg[31];
    assign last0_s        = s_axis_tvalid_0 & m_axis_tready & s_axis_tlast_0;
    assign last1_s        = s_axis_tvalid_1 & m_axis_tready & s_axis_tlast_1;
    assign inc0_s         = (state_r == SEND0) & last0_s;
    assign inc1_s         = (state_r == SEND1) & last1_s;
    assign pkt_done_s     = inc0_s | inc1_s;
    assign unused_ctrl_s  = ^{ctrl_reg[30:24], ctrl_reg[7:2]};

    assign grant_state = state_r;
    assign pkt_cnt_0   = pkt_cnt_0_r;
    assign pkt_cnt_1   = pkt_cnt_1_r;

    // Arbitration: next state, round-robin pointer and packet credit.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        credit_nxt_s = credit_r;
        case (state_r)
            IDLE: begin
                if (ptr_elig_s) begin
                    state_nxt_s = ptr_r ? SEND1 : SEND0;
                end else if (other_elig_s) begin
                    ptr_nxt_s    = ~ptr_r;
                    credit_nxt_s = other_weight_s;
                    state_nxt_s  = ptr_r ? SEND0 : SEND1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND0, SEND1: begin
                if (pkt_done_s) begin
                    state_nxt_s = IDLE;
                    if (credit_dec_s == 8'd0) begin
                        ptr_nxt_s    = ~ptr_r;
                        credit_nxt_s = other_weight_s;
                    end else begin
                        credit_nxt_s = credit_dec_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Packet counters: count completed packets; the clear bit overrides counting.
    always_comb begin
        pkt_cnt_0_nxt_s = pkt_cnt_0_r;
        pkt_cnt_1_nxt_s = pkt_cnt_1_r;
        if (cnt_clr_s) begin
            pkt_cnt_0_nxt_s = CNT_ZERO;
            pkt_cnt_1_nxt_s = CNT_ZERO;
        end else begin
            if (inc0_s) begin
                pkt_cnt_0_nxt_s = pkt_cnt_0_r + CNT_ONE;
            end else begin
                pkt_cnt_0_nxt_s = pkt_cnt_0_r;
            end
            if (inc1_s) begin
                pkt_cnt_1_nxt_s = pkt_cnt_1_r + CNT_ONE;
            end else begin
                pkt_cnt_1_nxt_s = pkt_cnt_1_r;
            end
        end
    end

    // Stream multiplexer: the granted input is passed straight through.
    always_comb begin
        m_axis_tdata    = {C_M_AXIS_DATA_WIDTH{1'b0}};
        m_axis_tstrb    = {(C_M_AXIS_DATA_WIDTH/8){1'b0}};
        m_axis_tuser    = {C_M_AXIS_TUSER_WIDTH{1'b0}};
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        s_axis_tready_0 = 1'b0;
        s_axis_tready_1 = 1'b0;
        case (state_r)
            SEND0: begin
                m_axis_tdata    = s_axis_tdata_0;
                m_axis_tstrb    = s_axis_tstrb_0;
                m_axis_tuser    = s_axis_tuser_0;
                m_axis_tvalid   = s_axis_tvalid_0;
                m_axis_tlast    = s_axis_tlast_0;
                s_axis_tready_0 = m_axis_tready;
            end
            SEND1: begin
                m_axis_tdata    = s_axis_tdata_1;
                m_axis_tstrb    = s_axis_tstrb_1;
                m_axis_tuser    = s_axis_tuser_1;
                m_axis_tvalid   = s_axis_tvalid_1;
                m_axis_tlast    = s_axis_tlast_1;
                s_axis_tready_1 = m_axis_tready;
            end
            IDLE: begin
                m_axis_tvalid = 1'b0;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    // State, pointer, credit and counter registers; reset aborts any packet.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_r     <= IDLE;
            ptr_r       <= 1'b0;
            credit_r    <= 8'd1;
            pkt_cnt_0_r <= CNT_ZERO;
            pkt_cnt_1_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            credit_r    <= credit_nxt_s;
            pkt_cnt_0_r <= pkt_cnt_0_nxt_s;
            pkt_cnt_1_r <= pkt_cnt_1_nxt_s;
        end
    end

endmodule

// File: tb/tb_mgmt_rr_arbiter.sv
// Testbench for mgmt_rr_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a packet-level reference model.
module tb_mgmt_rr_arbiter;
    localparam int DW = 64;
    localparam int UW = 16;
    localparam int RW = 32;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [DW-1:0]   s_axis_tdata_0, s_axis_tdata_1;
    logic [DW/8-1:0] s_axis_tstrb_0, s_axis_tstrb_1;
    logic [UW-1:0]   s_axis_tuser_0, s_axis_tuser_1;
    logic            s_axis_tvalid_0, s_axis_tvalid_1;
    logic            s_axis_tlast_0, s_axis_tlast_1;
    logic            s_axis_tready_0, s_axis_tready_1;
    logic [RW-1:0]   ctrl_reg;
    logic [RW-1:0]   pkt_cnt_0, pkt_cnt_1;
    logic [1:0]      grant_state;

    logic [1:0] en;
    logic [7:0] w0, w1;
    logic       clr;
    assign ctrl_reg = {clr, 7'd0, w1, w0, 6'd0, en};

    mgmt_rr_arbiter #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .C_S_AXI_DATA_WIDTH(RW)
    ) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .s_axis_tdata_0(s_axis_tdata_0), .s_axis_tstrb_0(s_axis_tstrb_0),
        .s_axis_tuser_0(s_axis_tuser_0), .s_axis_tvalid_0(s_axis_tvalid_0),
        .s_axis_tlast_0(s_axis_tlast_0), .s_axis_tready_0(s_axis_tready_0),
        .s_axis_tdata_1(s_axis_tdata_1), .s_axis_tstrb_1(s_axis_tstrb_1),
        .s_axis_tuser_1(s_axis_tuser_1), .s_axis_tvalid_1(s_axis_tvalid_1),
        .s_axis_tlast_1(s_axis_tlast_1), .s_axis_tready_1(s_axis_tready_1),
        .ctrl_reg(ctrl_reg), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1),
        .grant_state(grant_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: which port owns the output (-1 none), pointer, credit, counts
    int          busy;
    bit          mptr;
    int          mcredit;
    logic [31:0] mcnt [2];
    // packet sources
    int bid [2];
    int bidx [2];
    int blen [2];
    bit fixed_len;
    // grant order observed on the DUT
    int gorder [$];
    int last_gs;

    typedef struct {
        logic [1:0] en;
        logic [7:0] w0, w1;
        logic v0, v1, l0, l1, mr, clr;
        logic [1:0] gs;
        logic mv, r0, r1, ml;
        int c0, c1;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int effw(input logic [7:0] w);
        return (w == 8'd0) ? 1 : int'(w);
    endfunction

    function automatic logic [63:0] mkdata(input int p, input int id, input int idx);
        return {8'(p + 1), 24'(id), 16'(idx), 16'hC35A};
    endfunction

    function automatic logic [UW-1:0] mkuser(input int p, input int id, input int idx);
        return 16'(p * 32768 + id * 16 + idx);
    endfunction

    task automatic drive_src(input bit v0, input bit v1);
        s_axis_tdata_0  = mkdata(0, bid[0], bidx[0]);
        s_axis_tstrb_0  = 8'(bidx[0] + 1);
        s_axis_tuser_0  = mkuser(0, bid[0], bidx[0]);
        s_axis_tlast_0  = (bidx[0] == blen[0] - 1);
        s_axis_tvalid_0 = v0;
        s_axis_tdata_1  = mkdata(1, bid[1], bidx[1]);
        s_axis_tstrb_1  = 8'(bidx[1] + 1);
        s_axis_tuser_1  = mkuser(1, bid[1], bidx[1]);
        s_axis_tlast_1  = (bidx[1] == blen[1] - 1);
        s_axis_tvalid_1 = v1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 2'b11; w0 = 8'd1; w1 = 8'd1; clr = 1'b0; m_axis_tready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            bid[p] = 0; bidx[p] = 0;
            blen[p] = fixed_len ? 2 : int'($urandom_range(1, 4));
            mcnt[p] = 32'd0;
        end
        drive_src(1'b1, 1'b1);
        busy = -1; mptr = 1'b0; mcredit = 1; last_gs = 0;
        gorder.delete();
        @(negedge clk); #1;
        check("rst_grant", 64'(grant_state), 64'd0);
        check("rst_quiet", 64'({m_axis_tvalid, s_axis_tready_0, s_axis_tready_1}), 64'd0);
        check("rst_cnt", {pkt_cnt_0, pkt_cnt_1}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one clock of random traffic, checked against the reference model
    task automatic rand_cycle(input int vprob, input int rprob, input bit rctrl);
        bit v0, v1, l0, l1, xf0, xf1;
        bit el [2];
        int exp_gs;
        if (rctrl) begin
            if ($urandom_range(99) < 5) en = 2'($urandom_range(3));
            if ($urandom_range(99) < 5) begin
                w0 = 8'($urandom_range(3));
                w1 = 8'($urandom_range(3));
            end
            clr = ($urandom_range(99) < 3);
        end
        v0 = ($urandom_range(99) < vprob);
        v1 = ($urandom_range(99) < vprob);
        m_axis_tready = ($urandom_range(99) < rprob);
        drive_src(v0, v1);
        l0 = (bidx[0] == blen[0] - 1);
        l1 = (bidx[1] == blen[1] - 1);
        #1;
        if (last_gs == 0 && grant_state != 2'b00) gorder.push_back(int'(grant_state) - 1);
        last_gs = int'(grant_state);
        exp_gs = (busy < 0) ? 0 : busy + 1;
        check("grant_state", 64'(grant_state), 64'(exp_gs));
        check("pkt_cnts", {pkt_cnt_0, pkt_cnt_1}, {mcnt[0], mcnt[1]});
        if (busy < 0) begin
            check("idle_quiet", 64'({m_axis_tvalid, s_axis_tready_0, s_axis_tready_1}), 64'd0);
        end else if (busy == 0) begin
            check("mux0_data", m_axis_tdata, mkdata(0, bid[0], bidx[0]));
            check("mux0_side", 64'({m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast, s_axis_tready_0, s_axis_tready_1}),
                  64'({8'(bidx[0] + 1), mkuser(0, bid[0], bidx[0]), v0, l0, m_axis_tready, 1'b0}));
        end else begin
            check("mux1_data", m_axis_tdata, mkdata(1, bid[1], bidx[1]));
            check("mux1_side", 64'({m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast, s_axis_tready_0, s_axis_tready_1}),
                  64'({8'(bidx[1] + 1), mkuser(1, bid[1], bidx[1]), v1, l1, 1'b0, m_axis_tready}));
        end
        xf0 = (busy == 0) && v0 && m_axis_tready;
        xf1 = (busy == 1) && v1 && m_axis_tready;
        @(posedge clk);
        if (busy < 0) begin
            el[0] = en[0] && v0;
            el[1] = en[1] && v1;
            if (el[mptr]) begin
                busy = int'(mptr);
            end else if (el[!mptr]) begin
                mptr = !mptr;
                mcredit = effw(mptr ? w1 : w0);
                busy = int'(mptr);
            end
        end else if ((xf0 && l0) || (xf1 && l1)) begin
            mcnt[busy] = mcnt[busy] + 32'd1;
            mcredit = mcredit - 1;
            if (mcredit == 0) begin
                mptr = !mptr;
                mcredit = effw(mptr ? w1 : w0);
            end
            busy = -1;
        end
        if (clr) begin
            mcnt[0] = 32'd0;
            mcnt[1] = 32'd0;
        end
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 && xf0) || (p == 1 && xf1)) begin
                if (bidx[p] == blen[p] - 1) begin
                    bid[p]++; bidx[p] = 0;
                    blen[p] = fixed_len ? 2 : int'($urandom_range(1, 4));
                end else begin
                    bidx[p]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic sat_run(input logic [7:0] a, input logic [7:0] b, input int ncyc);
        fixed_len = 1'b1;
        do_reset();
        w0 = a; w1 = b; en = 2'b11;
        repeat (ncyc) rand_cycle(100, 100, 1'b0);
        #1;
    endtask

    function automatic int gget(input int i);
        return (i < gorder.size()) ? gorder[i] : 9;
    endfunction

    initial begin
        int beat, nb;
        int exp31 [10];
        rst = 1'b1;
        fixed_len = 1'b0;
        //            en     w0    w1    v0 v1 l0 l1 mr clr  gs   mv r0 r1 ml c0 c1
        tbl[0]  = '{2'b11, 8'd1, 8'd1, 0, 1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{2'b11, 8'd1, 8'd1, 0, 1, 0, 0, 1, 0, 2'd2, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{2'b11, 8'd1, 8'd1, 0, 1, 0, 1, 0, 0, 2'd2, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{2'b11, 8'd1, 8'd1, 0, 1, 0, 1, 1, 0, 2'd2, 1, 0, 1, 1, 0, 0};
        tbl[4]  = '{2'b11, 8'd1, 8'd1, 1, 1, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{2'b11, 8'd1, 8'd1, 1, 1, 1, 1, 1, 0, 2'd1, 1, 1, 0, 1, 0, 1};
        tbl[6]  = '{2'b11, 8'd1, 8'd1, 1, 1, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{2'b11, 8'd1, 8'd1, 1, 1, 1, 1, 1, 1, 2'd2, 1, 0, 1, 1, 1, 1};
        tbl[8]  = '{2'b11, 8'd1, 8'd1, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{2'b10, 8'd1, 8'd1, 1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{2'b10, 8'd1, 8'd1, 1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{2'b11, 8'd1, 8'd1, 1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{2'b10, 8'd1, 8'd1, 1, 0, 0, 0, 1, 0, 2'd1, 1, 1, 0, 0, 0, 0};
        tbl[13] = '{2'b10, 8'd1, 8'd1, 1, 0, 1, 0, 1, 0, 2'd1, 1, 1, 0, 1, 0, 0};
        tbl[14] = '{2'b10, 8'd1, 8'd1, 1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0};
        tbl[15] = '{2'b10, 8'd1, 8'd1, 1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0};
        exp31 = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

        // directed vector table
        do_reset();
        s_axis_tdata_0 = 64'hAAAA_0000_1111_2222;
        s_axis_tdata_1 = 64'h5555_3333_4444_6666;
        for (int i = 0; i < 16; i++) begin
            en = tbl[i].en; w0 = tbl[i].w0; w1 = tbl[i].w1; clr = tbl[i].clr;
            s_axis_tvalid_0 = tbl[i].v0; s_axis_tvalid_1 = tbl[i].v1;
            s_axis_tlast_0 = tbl[i].l0;  s_axis_tlast_1 = tbl[i].l1;
            m_axis_tready = tbl[i].mr;
            #1;
            check($sformatf("vec%0d_grant", i), 64'(grant_state), 64'(tbl[i].gs));
            check($sformatf("vec%0d_hs", i), 64'({m_axis_tvalid, s_axis_tready_0, s_axis_tready_1, m_axis_tlast & m_axis_tvalid}),
                  64'({tbl[i].mv, tbl[i].r0, tbl[i].r1, tbl[i].ml & tbl[i].mv}));
            check($sformatf("vec%0d_cnt", i), {pkt_cnt_0, pkt_cnt_1}, {32'(tbl[i].c0), 32'(tbl[i].c1)});
            if (tbl[i].gs == 2'd1) check($sformatf("vec%0d_data", i), m_axis_tdata, 64'hAAAA_0000_1111_2222);
            if (tbl[i].gs == 2'd2) check($sformatf("vec%0d_data", i), m_axis_tdata, 64'h5555_3333_4444_6666);
            @(posedge clk);
            @(negedge clk);
        end

        // 4-beat packet with m_axis_tready toggling
        fixed_len = 1'b0;
        do_reset();
        en = 2'b01;
        beat = 0; nb = 0;
        s_axis_tvalid_1 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            s_axis_tvalid_0 = (beat < 4);
            s_axis_tdata_0  = 64'h100 + 64'(beat);
            s_axis_tlast_0  = (beat == 3);
            m_axis_tready   = (c % 2 == 0);
            #1;
            if (grant_state == 2'b01 && m_axis_tvalid) begin
                check("stall_data", m_axis_tdata, 64'h100 + 64'(beat));
                check("stall_last", 64'(m_axis_tlast), 64'(beat == 3));
                check("stall_ready", 64'(s_axis_tready_0), 64'(c % 2 == 0));
            end
            if (s_axis_tvalid_0 && s_axis_tready_0) begin
                nb++;
                @(posedge clk);
                beat++;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        check("stall_beats", 64'(nb), 64'd4);
        check("stall_cnt", {pkt_cnt_0, pkt_cnt_1}, {32'd1, 32'd0});

        // reset in the middle of a packet
        do_reset();
        en = 2'b01;
        s_axis_tvalid_0 = 1'b1; s_axis_tlast_0 = 1'b1; s_axis_tvalid_1 = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        s_axis_tlast_0 = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        check("mid_grant", 64'(grant_state), 64'd1);
        check("mid_cnt", 64'(pkt_cnt_0), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_grant", 64'(grant_state), 64'd0);
        check("abort_quiet", 64'({m_axis_tvalid, s_axis_tready_0, s_axis_tready_1}), 64'd0);
        check("abort_cnt", {pkt_cnt_0, pkt_cnt_1}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_idle", 64'(grant_state), 64'd0);
        @(posedge clk); @(negedge clk); #1;
        check("post_rst_grant", 64'(grant_state), 64'd1);
        @(negedge clk);

        // saturated traffic, 2-beat packets
        sat_run(8'd1, 8'd1, 24);
        for (int i = 0; i < 8; i++) check($sformatf("rr11_order%0d", i), 64'(gget(i)), 64'(i % 2));
        check("rr11_cnt", {pkt_cnt_0, pkt_cnt_1}, {32'd4, 32'd4});
        @(negedge clk);
        sat_run(8'd3, 8'd1, 30);
        for (int i = 0; i < 10; i++) check($sformatf("rr31_order%0d", i), 64'(gget(i)), 64'(exp31[i]));
        check("rr31_cnt", {pkt_cnt_0, pkt_cnt_1}, {32'd7, 32'd3});
        @(negedge clk);
        sat_run(8'd0, 8'd1, 24);
        for (int i = 0; i < 8; i++) check($sformatf("rr01_order%0d", i), 64'(gget(i)), 64'(i % 2));
        check("rr01_cnt", {pkt_cnt_0, pkt_cnt_1}, {32'd4, 32'd4});
        @(negedge clk);

        // randomized traffic and control against the reference model
        fixed_len = 1'b0;
        do_reset();
        repeat (3000) rand_cycle(70, 70, 1'b1);
        repeat (1500) rand_cycle(95, 90, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
